regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Sequences and arbitrates the single-port, 64 × 16-bit register file between two requesters: the operand-fetch stage, which needs two register reads per instruction, and the writeback stage, which needs one register write. It sits between the pipeline stages and the register file. It owns the register file's data_in, reg_sel and mode inputs, and it captures data_out.

## Interface
Parameters:
- NREGSEL, 6, register select width (64 registers)
- W, 16, word width (matches `WORD)

Ports:
- clk  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- opf_req  in  1  operand-fetch request; held until opf_ack
- opf_rd  in  6  first operand register
- opf_rs  in  6  second operand register
- opf_ack  out  1  one-cycle pulse; opf_a/opf_b valid
- opf_a  out  16  value of reg[opf_rd]; held until next capture
- opf_b  out  16  value of reg[opf_rs]; held until next capture
- wb_req  in  1  writeback request; held until wb_ack
- wb_sel  in  6  destination register
- wb_data  in  16  write data
- wb_ack  out  1  one-cycle pulse; write is committed at the next rising edge
- rf_data_in  out  16  to register file data_in
- rf_sel  out  6  to register file reg_sel
- rf_mode  out  2  to register file mode: `regModeIdle / `regModeIn / `regModeOut
- rf_data_out  in  16  from register file data_out; registered inside the file, valid one edge after an edge that samples `regModeOut

## Operation
- FSM states: IDLE, WR, RA, RB, RC, DONE.
- rf_* outputs are registered and updated on state transitions.
- IDLE: arbitrate between wb_req and opf_req.
  - Writeback granted: go to WR. rf_mode=In, rf_sel=wb_sel, rf_data_in=wb_data.
  - Operand fetch granted: go to RA. rf_mode=Out, rf_sel=opf_rd.
  - Neither request: stay in IDLE. rf_mode=Idle.
- WR: wb_ack=1 (combinational from state). Go to IDLE with rf_mode=Idle.
- RA: go to RB with rf_sel=opf_rs (mode stays Out).
- RB: capture opf_a←rf_data_out. Go to RC with rf_mode=Idle.
- RC: capture opf_b←rf_data_out. Go to DONE.
- DONE: opf_ack=1 (combinational from state). Go to IDLE.
- Request inputs (opf_rd/opf_rs, wb_sel/wb_data) are sampled only at the IDLE grant edge. Later changes are ignored.
- A request still high in IDLE after its ack cycle starts a new transaction.
- Default arbitration is fixed priority, writeback first. A read granted after a pending write therefore always sees the new value. Under continuous wb_req, operand fetch starves; this is documented and accepted.
- opf_rd == opf_rs is legal: both reads are performed and opf_a == opf_b.
- wb_sel is not checked against in-flight reads. Ordering is decided only at the IDLE grant.

## Timing
- Write: grant edge E0 → wb_ack high E0..E1 → register file written at E1 → IDLE at E1.
- Read: grant E0 → opf_a captured E2, opf_b captured E3 → opf_ack high E3..E4 → IDLE at E4.
- Back-to-back: at most one grant per IDLE cycle, so consecutive transactions are separated by one IDLE cycle.
- Reset (clear_n low, any time): state=IDLE; rf_mode=Idle, rf_sel=0, rf_data_in=0; opf_a=opf_b=0; opf_ack=wb_ack=0; round-robin pointer=writeback.
- Reset mid-transaction aborts it: no ack is issued, and a write in WR is not guaranteed to commit.
- Release of clear_n is synchronous to clk; the first grant can occur at the first edge after release.

## Configuration
- REGSEQ_RR_EN defined: round-robin arbitration. When both requesters are waiting in IDLE, the grant alternates. The pointer flips after each contested grant; uncontested grants leave it unchanged. Read-after-write ordering becomes the requesters' responsibility.
- REGSEQ_RR_EN undefined: fixed writeback-first priority and no pointer register.

## Structure
- Shared constants in signals.v: `WORD, `REGSEL (6-bit), `regModeIdle, `regModeIn, `regModeOut, and the FSM state encodings `rsqIdle..`rsqDone.
- One natural sub-module: regseq_arbiter. It is the grant logic, with the optional round-robin pointer under REGSEQ_RR_EN.

## Test plan
- Reset: hold clear_n=0 with both requests high → no acks, rf_mode=Idle, opf_a=opf_b=0.
- Write then read: wb_req with sel=5, data=16'h00ff → wb_ack one cycle. Then opf_req with rd=5, rs=0 (reg0 preloaded to 16'h000f) → opf_a=16'h00ff, opf_b=16'h000f, opf_ack 4 edges after grant.
- Simultaneous requests, sel=rd=7, data=16'h1234, REGSEQ_RR_EN undefined → write first, then opf_a=16'h1234.
- Same stimulus with REGSEQ_RR_EN defined, both requests held for 4 transactions → grants alternate wb, opf, wb, opf.
- opf_rd=opf_rs=9 (reg9=16'hbeef) → opf_a=opf_b=16'hbeef.
- clear_n pulsed low while in RB → immediate IDLE, no opf_ack, opf_a=0. The next request completes normally.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// Shared widths, register-file mode encodings and sequencer states for regfile_sequencer.
package regfile_sequencer_pkg;

    localparam int unsigned REGSEL_W = 6;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned NUM_REGS = 64;

    typedef enum logic [1:0] {
        RF_MODE_IDLE = 2'd0,
        RF_MODE_IN   = 2'd1,
        RF_MODE_OUT  = 2'd2
    } rf_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RA   = 3'd2,
        ST_RB   = 3'd3,
        ST_RC   = 3'd4,
        ST_DONE = 3'd5
    } seq_state_e;

endpackage

// File: rtl/regfile_sequencer_arbiter.sv
// Grant logic between writeback and operand fetch; writeback-first by default,
// alternating on contention when REGSEQ_RR_EN is defined.
module regfile_sequencer_arbiter (
`ifdef REGSEQ_RR_EN
    input  logic clk,
    input  logic clear_n,
`endif
    input  logic arb_en,
    input  logic wb_req,
    input  logic opf_req,
    output logic grant_wb_c,
    output logic grant_opf_c
);

`ifdef REGSEQ_RR_EN
    logic prefer_opf_q;

    // Pointer flips only when both requesters compete for the same grant.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            prefer_opf_q <= 1'b0;
        end else if (arb_en && wb_req && opf_req) begin
            prefer_opf_q <= ~prefer_opf_q;
        end
    end

    always_comb begin
        grant_wb_c  = arb_en && wb_req  && (!opf_req || !prefer_opf_q);
        grant_opf_c = arb_en && opf_req && (!wb_req  ||  prefer_opf_q);
    end
`else
    always_comb begin
        grant_wb_c  = arb_en && wb_req;
        grant_opf_c = arb_en && opf_req && !wb_req;
    end
`endif

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences the single-port register file between operand fetch (two reads) and
// writeback (one write). Optional round-robin arbitration via REGSEQ_RR_EN.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int unsigned NREGSEL = REGSEL_W,
    parameter int unsigned W       = WORD_W
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               opf_req,
    input  logic [NREGSEL-1:0] opf_rd,
    input  logic [NREGSEL-1:0] opf_rs,
    output logic               opf_ack,
    output logic [W-1:0]       opf_a,
    output logic [W-1:0]       opf_b,
    input  logic               wb_req,
    input  logic [NREGSEL-1:0] wb_sel,
    input  logic [W-1:0]       wb_data,
    output logic               wb_ack,
    output logic [W-1:0]       rf_data_in,
    output logic [NREGSEL-1:0] rf_sel,
    output logic [1:0]         rf_mode,
    input  logic [W-1:0]       rf_data_out
);

    seq_state_e         state_q, state_d;
    rf_mode_e           mode_q, mode_d;
    logic [NREGSEL-1:0] sel_q, sel_d;
    logic [NREGSEL-1:0] rs_q, rs_d;
    logic [W-1:0]       data_in_q, data_in_d;
    logic [W-1:0]       opf_a_q, opf_a_d;
    logic [W-1:0]       opf_b_q, opf_b_d;
    logic               grant_wb_c, grant_opf_c;

    regfile_sequencer_arbiter u_arbiter (
`ifdef REGSEQ_RR_EN
        .clk         (clk),
        .clear_n     (clear_n),
`endif
        .arb_en      (state_q == ST_IDLE),
        .wb_req      (wb_req),
        .opf_req     (opf_req),
        .grant_wb_c  (grant_wb_c),
        .grant_opf_c (grant_opf_c)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= RF_MODE_IDLE;
            sel_q     <= '0;
            rs_q      <= '0;
            data_in_q <= '0;
            opf_a_q   <= '0;
            opf_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            rs_q      <= rs_d;
            data_in_q <= data_in_d;
            opf_a_q   <= opf_a_d;
            opf_b_q   <= opf_b_d;
        end
    end

    // Register-file data_out lags the Out-mode edge by one, so captures trail the selects.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sel_d     = sel_q;
        rs_d      = rs_q;
        data_in_d = data_in_q;
        opf_a_d   = opf_a_q;
        opf_b_d   = opf_b_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_wb_c) begin
                    state_d   = ST_WR;
                    mode_d    = RF_MODE_IN;
                    sel_d     = wb_sel;
                    data_in_d = wb_data;
                end else if (grant_opf_c) begin
                    state_d = ST_RA;
                    mode_d  = RF_MODE_OUT;
                    sel_d   = opf_rd;
                    rs_d    = opf_rs;
                end else begin
                    mode_d = RF_MODE_IDLE;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
                mode_d  = RF_MODE_IDLE;
            end
            ST_RA: begin
                state_d = ST_RB;
                sel_d   = rs_q;
            end
            ST_RB: begin
                state_d = ST_RC;
                mode_d  = RF_MODE_IDLE;
                opf_a_d = rf_data_out;
            end
            ST_RC: begin
                state_d = ST_DONE;
                opf_b_d = rf_data_out;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = RF_MODE_IDLE;
            end
        endcase
    end

    assign wb_ack     = (state_q == ST_WR);
    assign opf_ack    = (state_q == ST_DONE);
    assign opf_a      = opf_a_q;
    assign opf_b      = opf_b_q;
    assign rf_mode    = mode_q;
    assign rf_sel     = sel_q;
    assign rf_data_in = data_in_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register-file model, transaction-level reference and
// directed plus randomized stimulus.
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        opf_req = 1'b0;
    logic [5:0]  opf_rd = '0, opf_rs = '0;
    logic        opf_ack;
    logic [15:0] opf_a, opf_b;
    logic        wb_req = 1'b0;
    logic [5:0]  wb_sel = '0;
    logic [15:0] wb_data = '0;
    logic        wb_ack;
    logic [15:0] rf_data_in;
    logic [5:0]  rf_sel;
    logic [1:0]  rf_mode;
    logic [15:0] rf_data_out = '0;

    int checks = 0;
    int errors = 0;

    regfile_sequencer dut (
        .clk(clk), .clear_n(clear_n),
        .opf_req(opf_req), .opf_rd(opf_rd), .opf_rs(opf_rs),
        .opf_ack(opf_ack), .opf_a(opf_a), .opf_b(opf_b),
        .wb_req(wb_req), .wb_sel(wb_sel), .wb_data(wb_data), .wb_ack(wb_ack),
        .rf_data_in(rf_data_in), .rf_sel(rf_sel), .rf_mode(rf_mode),
        .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file the DUT drives: write on In, registered read on Out.
    logic [15:0] init_val [64];
    logic [15:0] rf_mem [64];
    bit          rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 64; i++) rf_mem[i] <= init_val[i];
            rf_loaded <= 1'b1;
        end else if (rf_mode == RF_MODE_IN) begin
            rf_mem[rf_sel] <= rf_data_in;
        end else if (rf_mode == RF_MODE_OUT) begin
            rf_data_out <= rf_mem[rf_sel];
        end
    end

    // Transaction-level reference: remaining cycles of the current transaction.
    logic [15:0] ref_mem [64];
    bit          ref_loaded = 1'b0;
    int          m_left = 0;
    bit          m_is_wr = 1'b0;
    logic [5:0]  m_sel = '0, m_rd = '0, m_rs = '0;
    logic [15:0] m_data = '0, exp_a = '0, exp_b = '0;
`ifdef REGSEQ_RR_EN
    bit          m_prefer_opf = 1'b0;
`endif
    bit          g_wb;

    always @(posedge clk or negedge clear_n) begin
        if (!ref_loaded) begin
            ref_mem = init_val;
            ref_loaded = 1'b1;
        end
        if (!clear_n) begin
            m_left = 0;
            exp_a = '0;
            exp_b = '0;
`ifdef REGSEQ_RR_EN
            m_prefer_opf = 1'b0;
`endif
        end else if (m_left == 0) begin
`ifdef REGSEQ_RR_EN
            g_wb = wb_req && (!opf_req || !m_prefer_opf);
            if (wb_req && opf_req) m_prefer_opf = !m_prefer_opf;
`else
            g_wb = wb_req;
`endif
            if (g_wb) begin
                m_is_wr = 1'b1; m_left = 1; m_sel = wb_sel; m_data = wb_data;
            end else if (opf_req) begin
                m_is_wr = 1'b0; m_left = 4; m_rd = opf_rd; m_rs = opf_rs;
            end
        end else begin
            if (m_is_wr) ref_mem[m_sel] = m_data;
            else if (m_left == 3) exp_a = ref_mem[m_rd];
            else if (m_left == 2) exp_b = ref_mem[m_rs];
            m_left--;
        end
    end

    always @(negedge clk) begin
        check("wb_ack", 16'(wb_ack), 16'(m_left == 1 && m_is_wr));
        check("opf_ack", 16'(opf_ack), 16'(m_left == 1 && !m_is_wr));
        check("opf_a", opf_a, exp_a);
        check("opf_b", opf_b, exp_b);
        if (!clear_n) check("rf_mode_rst", 16'(rf_mode), 16'(RF_MODE_IDLE));
    end

    task automatic wait_ack(input bit is_wb, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_wb ? wb_ack : opf_ack) && n < 20);
        if (!(is_wb ? wb_ack : opf_ack)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no %s ack after %0d cycles", is_wb ? "wb" : "opf", n);
        end
    endtask

    task automatic write_tx(input logic [5:0] sel, input logic [15:0] data, output int n);
        @(posedge clk); #2;
        wb_req = 1'b1; wb_sel = sel; wb_data = data;
        wait_ack(1'b1, n);
        @(posedge clk); #2;
        wb_req = 1'b0; wb_sel = 6'($urandom); wb_data = 16'($urandom);
    endtask

    task automatic read_tx(input logic [5:0] rd, input logic [5:0] rs, output int n);
        @(posedge clk); #2;
        opf_req = 1'b1; opf_rd = rd; opf_rs = rs;
        wait_ack(1'b0, n);
        @(posedge clk); #2;
        opf_req = 1'b0; opf_rd = 6'($urandom); opf_rs = 6'($urandom);
    endtask

    int  n;
    bit  order [4];
    bit  exp_order [4];
    int  got;
    bit  wa, oa;

    initial begin
        for (int i = 0; i < 64; i++) init_val[i] = 16'($urandom);
        init_val[0] = 16'h000f;
        init_val[9] = 16'hbeef;
        clear_n = 1'b0;

        // Reset held with both requests high.
        wb_req = 1'b1; opf_req = 1'b1; wb_sel = 6'd3; opf_rd = 6'd4;
        repeat (3) @(negedge clk);
        check("rst_wb_ack", 16'(wb_ack), 16'h0);
        check("rst_opf_ack", 16'(opf_ack), 16'h0);
        check("rst_rf_mode", 16'(rf_mode), 16'(RF_MODE_IDLE));
        check("rst_opf_a", opf_a, 16'h0);
        check("rst_opf_b", opf_b, 16'h0);
        @(posedge clk); #2;
        wb_req = 1'b0; opf_req = 1'b0; clear_n = 1'b1;

        // Write then read back.
        write_tx(6'd5, 16'h00ff, n);
        check("wr_latency", 16'(n), 16'd2);
        read_tx(6'd5, 6'd0, n);
        check("rd_latency", 16'(n), 16'd5);
        check("rd_a_lit", opf_a, 16'h00ff);
        check("rd_b_lit", opf_b, 16'h000f);

        // Simultaneous requests, each dropped after its ack.
        @(posedge clk); #2;
        wb_req = 1'b1; wb_sel = 6'd7; wb_data = 16'h1234;
        opf_req = 1'b1; opf_rd = 6'd7; opf_rs = 6'd0;
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            @(negedge clk);
            wa = wb_ack; oa = opf_ack;
            if (wa || oa) begin order[got] = wa; got++; end
            @(posedge clk); #2;
            if (wa) wb_req = 1'b0;
            if (oa) opf_req = 1'b0;
        end
        wb_req = 1'b0; opf_req = 1'b0;
        check("simul_count", 16'(got), 16'd2);
        check("simul_first_wb", 16'(order[0]), 16'h1);
        check("simul_second_opf", 16'(order[1]), 16'h0);
        check("simul_a_lit", opf_a, 16'h1234);
        check("simul_b_lit", opf_b, 16'h000f);

        // Both held for four transactions from a fresh reset.
        @(posedge clk); #2; clear_n = 1'b0;
        @(posedge clk); #2; clear_n = 1'b1;
        wb_req = 1'b1; wb_sel = 6'd7; wb_data = 16'h5678;
        opf_req = 1'b1; opf_rd = 6'd7; opf_rs = 6'd7;
`ifdef REGSEQ_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (wb_ack || opf_ack) begin order[got] = wb_ack; got++; end
        end
        @(posedge clk); #2;
        wb_req = 1'b0; opf_req = 1'b0;
        check("hold_count", 16'(got), 16'd4);
        for (int i = 0; i < 4; i++) check($sformatf("hold_grant%0d", i), 16'(order[i]), 16'(exp_order[i]));

        // Same register for both operands.
        read_tx(6'd9, 6'd9, n);
        check("same_a_lit", opf_a, 16'hbeef);
        check("same_b_lit", opf_b, 16'hbeef);

        // Reset while in RB aborts the read.
        @(posedge clk); #2;
        opf_req = 1'b1; opf_rd = 6'd9; opf_rs = 6'd0;
        @(posedge clk);
        @(posedge clk); #2;
        clear_n = 1'b0; opf_req = 1'b0;
        @(negedge clk);
        check("abort_a_lit", opf_a, 16'h0);
        @(posedge clk); #2; clear_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_ack", 16'(opf_ack), 16'h0);
        end
        read_tx(6'd9, 6'd0, n);
        check("post_abort_a_lit", opf_a, 16'hbeef);
        check("post_abort_b_lit", opf_b, 16'h000f);

        // Randomized traffic; request fields may change while waiting for a grant.
        repeat (3000) begin
            @(negedge clk);
            wa = wb_ack; oa = opf_ack;
            @(posedge clk); #2;
            if (!wb_req || wa) begin
                wb_req = ($urandom_range(0, 2) != 0);
                wb_sel = 6'($urandom); wb_data = 16'($urandom);
            end else if ($urandom_range(0, 1) == 1) begin
                wb_sel = 6'($urandom); wb_data = 16'($urandom);
            end
            if (!opf_req || oa) begin
                opf_req = ($urandom_range(0, 1) == 1);
                opf_rd = 6'($urandom); opf_rs = 6'($urandom);
            end else if ($urandom_range(0, 1) == 1) begin
                opf_rd = 6'($urandom); opf_rs = 6'($urandom);
            end
        end
        wb_req = 1'b0; opf_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
